rr_priority_arbiter: RTL and testbench

//  Parametrised N-way arbiter; next generation of the 8x3 priority encoder.

---
 rtl/rr_priority_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rr_priority_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
// N-way request arbiter with a registered one-hot grant, binary grant index
// and valid flag. Selection is either fixed priority (highest index wins) or
// round-robin, where the previous winner drops to lowest priority.
// A grant is locked until its owner pulses ack. On ack the arbiter
// re-arbitrates in the same cycle, so back-to-back grants have no idle bubble.

module rr_priority_arbiter #(
    parameter int N  = 8,
    parameter int RR = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 ack,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 valid
);

    localparam int W = $clog2(N);

    // N held in W+1 bits so that ptr + N - k never overflows before reduction
    localparam logic [W:0] N_EXT = (W+1)'(N);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [N-1:0]   grant_r;
    logic [N-1:0]   grant_s;
    logic [W-1:0]   idx_r;
    logic [W-1:0]   idx_s;
    logic           valid_r;
    logic           valid_s;
    logic [W-1:0]   ptr_r;
    logic [W-1:0]   ptr_s;

    logic           any_req_s;
    logic [W-1:0]   win_idx_s;
    logic           load_s;
    logic           clear_s;

    // Fixed priority: the highest set request index wins (later hits override)
    function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] r);
        logic [W-1:0] pick;
        pick = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                pick = W'(i);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Round-robin: search ptr-1, ptr-2, ..., 0, N-1, ..., ptr (mod N).
    // The loop walks from the lowest-priority slot (k = N, which is ptr
    // itself) towards the highest (k = 1), so the last hit is the winner.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [W-1:0] ptr);
        logic [W-1:0] pick;
        logic [W:0]   pos;
        pick = {W{1'b0}};
        for (int k = N; k >= 1; k--) begin
            pos = {1'b0, ptr} + N_EXT - (W+1)'(k);
            if (pos >= N_EXT) begin
                pos = pos - N_EXT;
            end else begin
                pos = pos;
            end
            if (r[pos[W-1:0]]) begin
                pick = pos[W-1:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // One-hot decode of a grant index
    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Winner selection from the live request vector
    always_comb begin
        any_req_s = |req;
        win_idx_s = {W{1'b0}};
        if (RR != 0) begin
            win_idx_s = rr_pick(req, ptr_r);
        end else begin
            win_idx_s = fixed_pick(req);
        end
    end

    // FSM next-state: decide whether to load a new grant, clear, or hold
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // ack is meaningless without an owner and is ignored here
                if (any_req_s) begin
                    load_s  = 1'b1;
                    state_s = ST_BUSY;
                end else begin
                    clear_s = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // req is only looked at on the ack cycle; otherwise frozen
                if (ack) begin
                    if (any_req_s) begin
                        load_s  = 1'b1;
                        state_s = ST_BUSY;
                    end else begin
                        clear_s = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                clear_s = 1'b1;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered grant outputs and the round-robin pointer
    always_comb begin
        grant_s = grant_r;
        idx_s   = idx_r;
        valid_s = valid_r;
        ptr_s   = ptr_r;
        if (load_s) begin
            grant_s = onehot(win_idx_s);
            idx_s   = win_idx_s;
            valid_s = 1'b1;
            // The winner becomes lowest priority; a lone re-requesting owner
            // simply reloads the same pointer value
            if (RR != 0) begin
                ptr_s = win_idx_s;
            end else begin
                ptr_s = {W{1'b0}};
            end
        end else if (clear_s) begin
            grant_s = {N{1'b0}};
            idx_s   = {W{1'b0}};
            valid_s = 1'b0;
            ptr_s   = ptr_r;
        end else begin
            grant_s = grant_r;
            idx_s   = idx_r;
            valid_s = valid_r;
            ptr_s   = ptr_r;
        end
    end

    // State and output registers; synchronous reset wins over any request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            grant_r <= {N{1'b0}};
            idx_r   <= {W{1'b0}};
            valid_r <= 1'b0;
            ptr_r   <= {W{1'b0}};
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            idx_r   <= idx_s;
            valid_r <= valid_s;
            ptr_r   <= ptr_s;
        end
    end

    assign grant     = grant_r;
    assign grant_idx = idx_r;
    assign valid     = valid_r;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter: fixed priority (N=8), round-robin
// (N=8) and round-robin with non-power-of-2 width (N=5).

module tb_rr_priority_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // DUT 0: N=8, fixed priority
    logic       d0_rst, d0_ack, d0_valid;
    logic [7:0] d0_req, d0_grant;
    logic [2:0] d0_idx;
    // DUT 1: N=8, round-robin
    logic       d1_rst, d1_ack, d1_valid;
    logic [7:0] d1_req, d1_grant;
    logic [2:0] d1_idx;
    // DUT 2: N=5, round-robin
    logic       d2_rst, d2_ack, d2_valid;
    logic [4:0] d2_req, d2_grant;
    logic [2:0] d2_idx;

    logic [2:0] seq8 [9];
    logic [2:0] seq5 [6];
    logic [7:0] exp_g8;
    logic [4:0] exp_g5;
    logic [7:0] one8;
    logic [4:0] one5;

    rr_priority_arbiter #(.N(8), .RR(0)) u_fix8 (
        .clk(clk), .rst(d0_rst), .req(d0_req), .ack(d0_ack),
        .grant(d0_grant), .grant_idx(d0_idx), .valid(d0_valid));

    rr_priority_arbiter #(.N(8), .RR(1)) u_rr8 (
        .clk(clk), .rst(d1_rst), .req(d1_req), .ack(d1_ack),
        .grant(d1_grant), .grant_idx(d1_idx), .valid(d1_valid));

    rr_priority_arbiter #(.N(5), .RR(1)) u_rr5 (
        .clk(clk), .rst(d2_rst), .req(d2_req), .ack(d2_ack),
        .grant(d2_grant), .grant_idx(d2_idx), .valid(d2_valid));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
        check({tag, ".grant"}, {24'd0, d0_grant}, {24'd0, g});
        check({tag, ".idx"},   {29'd0, d0_idx},   {29'd0, i});
        check({tag, ".valid"}, {31'd0, d0_valid}, {31'd0, v});
    endtask

    task automatic chk1(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
        check({tag, ".grant"}, {24'd0, d1_grant}, {24'd0, g});
        check({tag, ".idx"},   {29'd0, d1_idx},   {29'd0, i});
        check({tag, ".valid"}, {31'd0, d1_valid}, {31'd0, v});
    endtask

    task automatic chk2(input string tag, input logic [4:0] g, input logic [2:0] i, input logic v);
        check({tag, ".grant"}, {27'd0, d2_grant}, {27'd0, g});
        check({tag, ".idx"},   {29'd0, d2_idx},   {29'd0, i});
        check({tag, ".valid"}, {31'd0, d2_valid}, {31'd0, v});
    endtask

    // Directed stimulus sequence with hand-computed expectations
    initial begin
        seq8 = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        seq5 = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
        one8 = 8'd1;
        one5 = 5'd1;

        // Reset held with every line requesting: outputs stay clear
        d0_rst = 1'b1; d1_rst = 1'b1; d2_rst = 1'b1;
        d0_req = 8'hFF; d1_req = 8'hFF; d2_req = 5'h1F;
        d0_ack = 1'b0; d1_ack = 1'b0; d2_ack = 1'b0;
        tick();
        chk0("rst1.fix8", 8'h00, 3'd0, 1'b0);
        chk1("rst1.rr8",  8'h00, 3'd0, 1'b0);
        chk2("rst1.rr5",  5'h00, 3'd0, 1'b0);
        tick();
        chk0("rst2.fix8", 8'h00, 3'd0, 1'b0);
        chk1("rst2.rr8",  8'h00, 3'd0, 1'b0);
        chk2("rst2.rr5",  5'h00, 3'd0, 1'b0);

        // Fixed priority: highest set index wins, re-granted on ack
        d0_rst = 1'b0; d0_req = 8'b1001_1011;
        tick();
        chk0("fix.first", 8'h80, 3'd7, 1'b1);
        d0_ack = 1'b1;
        tick();
        chk0("fix.reack", 8'h80, 3'd7, 1'b1);
        d0_ack = 1'b0;
        tick();
        chk0("fix.hold", 8'h80, 3'd7, 1'b1);
        d0_req = 8'h00; d0_ack = 1'b1;
        tick();
        check("fix.release.valid", {31'd0, d0_valid}, 32'd0);
        check("fix.release.grant", {24'd0, d0_grant}, 32'd0);
        // ack with no owner does nothing
        tick();
        check("fix.idle_ack.valid", {31'd0, d0_valid}, 32'd0);
        d0_ack = 1'b0; d0_req = 8'b0001_0110;
        tick();
        chk0("fix.idx4", 8'h10, 3'd4, 1'b1);
        // Owner drops request: grant stays locked until ack
        d0_req = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk0("fix.locked", 8'h10, 3'd4, 1'b1);
        end
        // Higher request while busy is ignored
        d0_req = 8'hE0;
        tick();
        chk0("fix.frozen", 8'h10, 3'd4, 1'b1);
        d0_req = 8'h00; d0_ack = 1'b1;
        tick();
        check("fix.drop.valid", {31'd0, d0_valid}, 32'd0);
        check("fix.drop.grant", {24'd0, d0_grant}, 32'd0);
        d0_ack = 1'b0;

        // Round-robin N=8, all requesting, ack held: 7..0 then wrap to 7
        d1_rst = 1'b0; d1_req = 8'hFF; d1_ack = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp_g8 = one8 << seq8[k];
            chk1("rr8.sweep", exp_g8, seq8[k], 1'b1);
        end
        // Reset mid-grant clears at once, no ack needed
        d1_ack = 1'b0; d1_rst = 1'b1;
        tick();
        chk1("rr8.midrst", 8'h00, 3'd0, 1'b0);
        d1_rst = 1'b0; d1_req = 8'b0000_0101;
        tick();
        chk1("rr8.pair.a", 8'h04, 3'd2, 1'b1);
        d1_ack = 1'b1;
        tick();
        chk1("rr8.pair.b", 8'h01, 3'd0, 1'b1);
        tick();
        chk1("rr8.pair.c", 8'h04, 3'd2, 1'b1);
        d1_req = 8'h00;
        tick();
        check("rr8.pair.end.valid", {31'd0, d1_valid}, 32'd0);
        check("rr8.pair.end.grant", {24'd0, d1_grant}, 32'd0);
        // Lone owner re-granted on ack; pointer then favours index below it
        d1_req = 8'b0000_1000; d1_ack = 1'b0;
        tick();
        chk1("rr8.lone.a", 8'h08, 3'd3, 1'b1);
        d1_ack = 1'b1;
        tick();
        chk1("rr8.lone.b", 8'h08, 3'd3, 1'b1);
        d1_req = 8'b0000_1100;
        tick();
        chk1("rr8.after_lone", 8'h04, 3'd2, 1'b1);
        d1_req = 8'h00;
        tick();
        check("rr8.final.valid", {31'd0, d1_valid}, 32'd0);
        d1_ack = 1'b0;

        // Round-robin N=5: wrap modulo a non-power-of-2 width
        d2_rst = 1'b0; d2_req = 5'h1F; d2_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_g5 = one5 << seq5[k];
            chk2("rr5.sweep", exp_g5, seq5[k], 1'b1);
        end
        d2_ack = 1'b0; d2_rst = 1'b1;
        tick();
        chk2("rr5.midrst", 5'h00, 3'd0, 1'b0);
        d2_rst = 1'b0; d2_req = 5'b00010;
        tick();
        chk2("rr5.idx1", 5'h02, 3'd1, 1'b1);
        d2_req = 5'b10001; d2_ack = 1'b1;
        tick();
        chk2("rr5.idx0", 5'h01, 3'd0, 1'b1);
        tick();
        chk2("rr5.wrap4", 5'h10, 3'd4, 1'b1);
        d2_req = 5'h00;
        tick();
        check("rr5.end.valid", {31'd0, d2_valid}, 32'd0);
        check("rr5.end.grant", {27'd0, d2_grant}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
